// File: rtl/matmul_row_scheduler_pkg.sv
// matmul_pkg: shared FSM state encoding and width helpers for the row scheduler
// Ports: none (package).
package matmul_pkg;
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FINISH} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int lane_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction
endpackage

// File: rtl/matmul_row_scheduler_if.sv
// matmul_row_scheduler_if: job dispatch / lane completion bundle of the row scheduler
// Ports: start, lane_done (requester -> scheduler); job_valid, job_lane, job_row,
// job_col, lane_busy, busy, done, err (scheduler -> requester).
interface matmul_row_scheduler_if
    import matmul_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int IDX_W = 8
);
    localparam int LANE_W = lane_w(NUM_LANES);
    logic start;
    logic [NUM_LANES-1:0] lane_done;
    logic job_valid;
    logic [LANE_W-1:0] job_lane;
    logic [IDX_W-1:0] job_row;
    logic [IDX_W-1:0] job_col;
    logic [NUM_LANES-1:0] lane_busy;
    logic busy;
    logic done;
    logic err;
    modport master(
        output start, lane_done,
        input job_valid, job_lane, job_row, job_col, lane_busy, busy, done, err
    );
    modport slave(
        input start, lane_done,
        output job_valid, job_lane, job_row, job_col, lane_busy, busy, done, err
    );
endinterface

// File: rtl/matmul_row_scheduler_arbiter.sv
// rr_lane_arbiter: picks the first requesting lane at or after the pointer, with wrap-around
// Ports: req (requesting lanes), ptr (round-robin start), gnt (granted lane), gnt_valid.
module rr_lane_arbiter #(
    parameter int NUM_LANES = 2,
    parameter int LANE_W = 1
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    ptr,
    output logic [LANE_W-1:0]    gnt,
    output logic                 gnt_valid
);
    logic [2*NUM_LANES-1:0] dbl;
    logic [NUM_LANES-1:0] rot;
    assign dbl = {req, req};
    // rot[k] is the request of lane (ptr + k) mod NUM_LANES
    assign rot = NUM_LANES'(dbl >> ptr);
    always_comb begin
        gnt = '0;
        gnt_valid = 1'b0;
        // descending scan so the smallest offset from ptr wins
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt = LANE_W'((int'(ptr) + k >= NUM_LANES) ? int'(ptr) + k - NUM_LANES : int'(ptr) + k);
                gnt_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/matmul_row_scheduler.sv
// matmul_row_scheduler: dispatches res[row][col] elements of A*B to MAC lanes round-robin
// Ports: clk, rst (async active-high); bus (slave side of matmul_row_scheduler_if):
// start/lane_done in, job_valid/job_lane/job_row/job_col/lane_busy/busy/done/err out.
module matmul_row_scheduler
    import matmul_pkg::*;
#(
    parameter int A_ROWS = 2,
    parameter int A_COLS = 2,
    parameter int B_ROWS = 2,
    parameter int B_COLS = 2,
    parameter int NUM_LANES = 2,
    parameter int IDX_W = 8
) (
    input logic clk,
    input logic rst,
    matmul_row_scheduler_if.slave bus
);
    localparam int LANE_W = lane_w(NUM_LANES);
    localparam int TOTAL = A_ROWS * B_COLS;
    localparam int CNT_W = clog2(TOTAL + 1);
    state_t state;
    logic [IDX_W-1:0] row, col;
    logic [CNT_W-1:0] cnt, n_freed;
    logic [LANE_W-1:0] ptr, gnt;
    logic gnt_valid, last;
    logic [NUM_LANES-1:0] freed, req;
    logic valid_q, busy_q, done_q, err_q;
    logic [LANE_W-1:0] lane_q;
    logic [IDX_W-1:0] row_q, col_q;
    logic [NUM_LANES-1:0] lane_busy_q;
    // a lane completing this cycle is free again before arbitration
    assign freed = bus.lane_done & lane_busy_q;
    assign req = (state == DISPATCH) ? ~(lane_busy_q & ~freed) : '0;
    assign last = (row == IDX_W'(A_ROWS - 1)) && (col == IDX_W'(B_COLS - 1));
    always_comb begin
        n_freed = '0;
        for (int i = 0; i < NUM_LANES; i++) n_freed = n_freed + CNT_W'(freed[i]);
    end
    rr_lane_arbiter #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(gnt),
        .gnt_valid(gnt_valid)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row <= '0;
            col <= '0;
            cnt <= '0;
            ptr <= '0;
            valid_q <= 1'b0;
            lane_q <= '0;
            row_q <= '0;
            col_q <= '0;
            lane_busy_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            lane_q <= '0;
            row_q <= '0;
            col_q <= '0;
            done_q <= 1'b0;
            lane_busy_q <= lane_busy_q & ~freed;
            cnt <= cnt + n_freed;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (A_COLS == B_ROWS) begin
                            state <= DISPATCH;
                            busy_q <= 1'b1;
                            row <= '0;
                            col <= '0;
                            cnt <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DISPATCH: begin
                    if (gnt_valid) begin
                        lane_busy_q <= (lane_busy_q & ~freed) | (NUM_LANES'(1) << gnt);
                        valid_q <= 1'b1;
                        lane_q <= gnt;
                        row_q <= row;
                        col_q <= col;
                        ptr <= (gnt == LANE_W'(NUM_LANES - 1)) ? '0 : gnt + LANE_W'(1);
                        if (last) begin
                            state <= DRAIN;
                            row <= '0;
                            col <= '0;
                        end else if (col == IDX_W'(B_COLS - 1)) begin
                            col <= '0;
                            row <= row + IDX_W'(1);
                        end else begin
                            col <= col + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_W'(TOTAL)) begin
                        state <= FINISH;
                        done_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
    assign bus.job_valid = valid_q;
    assign bus.job_lane = lane_q;
    assign bus.job_row = row_q;
    assign bus.job_col = col_q;
    assign bus.lane_busy = lane_busy_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err = err_q;
endmodule

// File: doc/matmul_row_scheduler.md
MATMUL_ROW_SCHEDULER -- requirements
Module: matmul_row_scheduler

Interface
REQ-001 SHALL have parameter A_ROWS, default 2: rows of matrix A.
REQ-002 SHALL have parameter A_COLS, default 2: columns of matrix A.
REQ-003 SHALL have parameter B_ROWS, default 2: rows of matrix B.
REQ-004 SHALL have parameter B_COLS, default 2: columns of matrix B.
REQ-005 SHALL have parameter NUM_LANES, default 2: number of parallel MAC lanes to be scheduled.
REQ-006 SHALL have parameter IDX_W, default 8: width of row and column indices.
REQ-007 SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-008 Port clk, input, 1 bit: rising-edge clock.
REQ-009 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-010 Port start, input, 1 bit: a one-cycle pulse that begins a multiply job.
REQ-011 Port lane_done, input, NUM_LANES bits: per-lane one-cycle pulse meaning the assigned element is written.
REQ-012 Port job_valid, output, 1 bit: a dispatch is issued this cycle.
REQ-013 Port job_lane, output, clog2(NUM_LANES) bits (minimum 1): target lane of the dispatch.
REQ-014 Port job_row / job_col, outputs, IDX_W bits each: result element res[row][col] to compute.
REQ-015 Port lane_busy, output, NUM_LANES bits: a lane holds an outstanding job.
REQ-016 Port busy, output, 1 bit: the FSM is not IDLE.
REQ-017 Port done, output, 1 bit: a one-cycle pulse when all A_ROWS*B_COLS elements have completed.
REQ-018 Port err, output, 1 bit: sticky dimension-mismatch flag.

Function
REQ-019 FSM SHALL have states IDLE, DISPATCH, DRAIN and FINISH.
REQ-020 IDLE->DISPATCH SHALL occur on start=1 when A_COLS==B_ROWS; row and column counters SHALL clear to 0.
REQ-021 On start=1 with A_COLS!=B_ROWS, err SHALL set to 1 on the next edge and the FSM SHALL stay in IDLE.
REQ-022 err SHALL clear only on rst.
REQ-023 start SHALL be ignored when busy=1.
REQ-024 In DISPATCH, the FSM SHALL issue at most one job per cycle, to the first non-busy lane at or after the round-robin pointer, with wrap-around.
REQ-025 No job SHALL be issued when all lanes are busy.
REQ-026 job_valid, job_lane, job_row and job_col SHALL be registered outputs, valid in the same cycle, with 1-cycle latency from the arbitration decision.
REQ-027 job_row and job_col SHALL be 0 whenever job_valid=0.
REQ-028 Element order SHALL be row-major: col increments, wraps to 0 after B_COLS-1, and row then increments.
REQ-029 After each grant, the round-robin pointer SHALL advance to granted lane+1, modulo NUM_LANES.
REQ-030 Granting a lane SHALL set its lane_busy bit; lane_done on a busy lane SHALL clear that bit and increment the completion counter.
REQ-031 lane_done on a non-busy lane SHALL be ignored.
REQ-032 When lane_done and a grant name the same lane in the same cycle, the lane SHALL be freed before arbitration, so the lane is re-granted and lane_busy stays 1.
REQ-033 After the last element (row A_ROWS-1, col B_COLS-1) is issued, DISPATCH->DRAIN SHALL occur.
REQ-034 DRAIN->FINISH SHALL occur when the completion counter reaches A_ROWS*B_COLS.
REQ-035 FINISH SHALL assert done for exactly one cycle and then return to IDLE.
REQ-036 Completion counter width SHALL be clog2(A_ROWS*B_COLS+1) bits.
REQ-037 Index counters SHALL never exceed A_ROWS-1 or B_COLS-1.

Reset
REQ-038 rst=1 SHALL asynchronously force: FSM to IDLE; all counters and the round-robin pointer to 0; and job_valid, job_lane, job_row, job_col, lane_busy, busy, done and err to 0.
REQ-039 rst asserted mid-operation SHALL abandon outstanding jobs.
REQ-040 lane_done pulses arriving after rst deasserts SHALL be ignored.

Structure
REQ-041 The FSM state encoding and the clog2 helper function SHALL live in the shared package matmul_pkg.
REQ-042 The round-robin arbiter SHALL be the sub-module rr_lane_arbiter (inputs: request vector, pointer; outputs: grant index, grant valid).
REQ-043 All other logic SHALL reside in matmul_row_scheduler.

Verification
REQ-044 Defaults, start pulse, each lane returning lane_done 3 cycles after its grant -> 4 dispatches (0,0)L0, (0,1)L1, (1,0)L0, (1,1)L1; done pulses once; busy falls the cycle after done.
REQ-045 B_ROWS=3 with A_COLS=2, start -> err=1, no job_valid, busy stays 0; err remains 1 until rst.
REQ-046 NUM_LANES=2, lanes never return done -> exactly 2 jobs issued; FSM holds in DISPATCH with lane_busy=2'b11.
REQ-047 lane_done[1] pulsed while lane 1 is idle -> completion counter unchanged; done never asserts early.
REQ-048 rst pulsed after 2 of 4 jobs issued -> all outputs 0 immediately; a new start reissues from (0,0) on lane 0.
REQ-049 start pulsed again while busy -> ignored; the job sequence is identical to REQ-044.
